// File: rtl/spi_pkg.sv
// Shared types and default constants for the burst SPI master and its
// half-period timer.
package spi_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIV_W  = 8;
  localparam int DEF_CNT_W  = 10;
  localparam int DEF_N_CS   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_STORE,
    ST_HOLD
  } spi_state_t;

  // Bit 1 is CPOL, bit 0 is CPHA.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: reloads div_i while disabled, then ticks once every
// div_i+1 enabled cycles.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] r_cnt;

  assign tick_o = en_i && (r_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (!en_i || tick_o) begin
      r_cnt <= div_i;
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_burst.sv
// SPI master that streams n_tx_end_i+1 words under one chip select, reading
// transmit words by index and writing each received word back by index.
module spi_master_burst
  import spi_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DIV_W  = DEF_DIV_W,
  parameter  int CNT_W  = DEF_CNT_W,
  parameter  int N_CS   = DEF_N_CS,
  localparam int SEL_W  = sel_width(N_CS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [SEL_W-1:0]  cs_sel_i,
  input  logic [CNT_W-1:0]  n_tx_end_i,
  input  logic              all_1s_i,
  input  logic              all_0s_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [N_CS-1:0]   cs_n_o,
  output logic [CNT_W-1:0]  tx_addr_o,
  output logic [CNT_W-1:0]  rx_addr_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_we_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  spi_state_t        r_state;
  spi_mode_t         r_mode;
  logic [DIV_W-1:0]  r_div;
  logic [SEL_W-1:0]  r_sel;
  logic [CNT_W-1:0]  r_n_end, r_idx, r_rx_addr;
  logic              r_all1, r_all0;
  logic [DATA_W-1:0] r_tx_sh, r_rx_sh, r_rx_data;
  logic [EDGE_W-1:0] r_edge;
  logic [N_CS-1:0]   r_cs_n;
  logic              r_sclk, r_mosi, r_we, r_busy, r_done;

  logic [N_CS-1:0]   w_cs_dec;
  logic              w_div_en, w_tick, w_cpha, w_sample, w_force, w_next_bit;

  // An out-of-range select matches no line, so every chip select stays high.
  for (genvar gi = 0; gi < N_CS; gi++) begin : g_cs_dec
    assign w_cs_dec[gi] = (r_sel != SEL_W'(gi));
  end

  assign w_div_en   = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
  assign w_cpha     = r_mode[0];
  // Even edge counts are leading edges; CPHA picks which kind samples.
  assign w_sample   = ~r_edge[0] ^ w_cpha;
  assign w_force    = r_all1 | r_all0;
  assign w_next_bit = w_cpha ? r_tx_sh[DATA_W-1] : r_tx_sh[DATA_W-2];

  spi_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_div_en),
    .div_i  (r_div),
    .tick_o (w_tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_mode    <= SPI_MODE0;
      r_div     <= '0;
      r_sel     <= '0;
      r_n_end   <= '0;
      r_idx     <= '0;
      r_rx_addr <= '0;
      r_all1    <= 1'b0;
      r_all0    <= 1'b0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_edge    <= '0;
      r_cs_n    <= '1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_mode  <= spi_mode_t'({cpol_i, cpha_i});
            r_div   <= div_i;
            r_sel   <= cs_sel_i;
            r_n_end <= n_tx_end_i;
            r_all1  <= all_1s_i;
            r_all0  <= all_0s_i;
            r_idx   <= '0;
            r_sclk  <= cpol_i;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_tx_sh <= tx_data_i;
          r_mosi  <= w_force ? r_all1 : tx_data_i[DATA_W-1];
          r_cs_n  <= w_cs_dec;
          r_sclk  <= r_mode[1];
          r_edge  <= '0;
          r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (w_tick) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + EDGE_W'(1);
            if (w_sample) begin
              r_rx_sh <= {r_rx_sh[DATA_W-2:0], miso_i};
            end else begin
              r_tx_sh <= r_tx_sh << 1;
              r_mosi  <= w_force ? r_all1 : w_next_bit;
            end
            if (r_edge == LAST_EDGE) r_state <= ST_STORE;
          end
        end
        ST_STORE: begin
          r_rx_data <= r_rx_sh;
          r_rx_addr <= r_idx;
          r_we      <= 1'b1;
          // Compare before incrementing so a full-range burst never wraps.
          if (r_idx == r_n_end) begin
            r_state <= ST_HOLD;
          end else begin
            r_idx   <= r_idx + CNT_W'(1);
            r_state <= ST_LOAD;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_cs_n  <= '1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sclk_o    = r_sclk;
  assign mosi_o    = r_mosi;
  assign cs_n_o    = r_cs_n;
  assign tx_addr_o = r_idx;
  assign rx_addr_o = r_rx_addr;
  assign rx_data_o = r_rx_data;
  assign rx_we_o   = r_we;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule

// File: tb/tb_spi_master_burst.sv
// Randomised and directed bursts checked against a word-level model of the
// expected received data, SCLK edge timing, chip-select activity and MOSI forcing.
module tb_spi_master_burst;

  localparam int DW  = 8;
  localparam int DVW = 8;
  localparam int CW  = 4;
  localparam int NCS = 3;
  localparam int SW  = 2;
  localparam int NW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, cpol = 1'b0, cpha = 1'b0, all1 = 1'b0, all0 = 1'b0;
  logic [DVW-1:0] div = '0;
  logic [SW-1:0]  sel = '0;
  logic [CW-1:0]  nend = '0;
  logic [DW-1:0]  tx_data;
  logic           miso;
  logic           sclk, mosi, rx_we, busy, done;
  logic [NCS-1:0] cs_n;
  logic [CW-1:0]  tx_addr, rx_addr;
  logic [DW-1:0]  rx_data;

  logic [DW-1:0] tx_mem [NW];
  logic [DW-1:0] sl_mem [NW];
  logic loopback = 1'b1;
  logic s_miso = 1'b0;

  // Burst configuration as seen by the monitor and slave model.
  logic m_cpol = 1'b0, m_cpha = 1'b0, m_f1 = 1'b0, m_f0 = 1'b0;
  int   m_div = 0;

  // Monitor-owned running totals; bursts compare deltas against snapshots.
  int cyc = 0, last_edge_cyc = 0, burst_edges = 0, edges_tot = 0;
  int bad_space = 0, done_cnt = 0, mviol = 0, idle_bad = 0, bidx;
  int cs_fall [NCS];
  int cs_rise [NCS];
  int rxa_q [$];
  int rxd_q [$];
  logic prev_busy = 1'b0, prev_sclk = 1'b0;
  logic [NCS-1:0] prev_cs = '1;

  int n_checks = 0, n_fail = 0, n_burst = 0;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : s_miso;

  spi_master_burst #(
    .DATA_W (DW),
    .DIV_W  (DVW),
    .CNT_W  (CW),
    .N_CS   (NCS)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .cpol_i     (cpol),
    .cpha_i     (cpha),
    .div_i      (div),
    .cs_sel_i   (sel),
    .n_tx_end_i (nend),
    .all_1s_i   (all1),
    .all_0s_i   (all0),
    .tx_data_i  (tx_data),
    .miso_i     (miso),
    .sclk_o     (sclk),
    .mosi_o     (mosi),
    .cs_n_o     (cs_n),
    .tx_addr_o  (tx_addr),
    .rx_addr_o  (rx_addr),
    .rx_data_o  (rx_data),
    .rx_we_o    (rx_we),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial begin
    for (int i = 0; i < NCS; i++) begin
      cs_fall[i] = 0;
      cs_rise[i] = 0;
    end
  end

  // Transmit memory answers within the cycle after the address changes.
  always @(negedge clk) tx_data = tx_mem[tx_addr];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      burst_edges = 0;
    end else begin
      if (rx_we) begin
        rxa_q.push_back(int'(rx_addr));
        rxd_q.push_back(int'(rx_data));
      end
      if (done) done_cnt++;
      if (busy && prev_busy && (sclk !== prev_sclk)) begin
        if ((burst_edges % (2 * DW)) != 0 && (cyc - last_edge_cyc) != m_div + 1) bad_space++;
        last_edge_cyc = cyc;
        burst_edges++;
        edges_tot++;
      end
      if (!busy) burst_edges = 0;
      for (int i = 0; i < NCS; i++) begin
        if (prev_cs[i] && !cs_n[i]) begin
          cs_fall[i]++;
          if (sclk !== m_cpol) idle_bad++;
        end
        if (!prev_cs[i] && cs_n[i]) cs_rise[i]++;
      end
      if ((cs_n != '1) && (m_f1 || m_f0) && (mosi !== m_f1)) mviol++;
    end
    prev_busy = busy;
    prev_sclk = sclk;
    prev_cs   = cs_n;
    // Slave: global bit index from edges seen; CPHA=1 advances on leading edges.
    bidx = m_cpha ? ((burst_edges == 0) ? 0 : (burst_edges - 1) / 2) : burst_edges / 2;
    s_miso = sl_mem[(bidx / DW) % NW][DW - 1 - (bidx % DW)];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_burst(input string name, input logic p_cpol, input logic p_cpha,
                           input int p_div, input int p_sel, input int p_nend,
                           input logic p_f1, input logic p_f0, input logic p_loop,
                           input bit p_extra);
    int nw, b_edges, b_bad, b_done, b_mv, b_idle, b_rx;
    int b_fall [NCS];
    int b_rise [NCS];
    logic [DW-1:0] exp_d;
    bit fin;
    fin = 1'b0;
    nw  = p_nend + 1;
    m_cpol = p_cpol; m_cpha = p_cpha; m_div = p_div; m_f1 = p_f1; m_f0 = p_f0;
    loopback = p_loop;
    @(negedge clk);
    b_edges = edges_tot; b_bad = bad_space; b_done = done_cnt; b_mv = mviol;
    b_idle = idle_bad; b_rx = rxa_q.size();
    for (int i = 0; i < NCS; i++) begin
      b_fall[i] = cs_fall[i];
      b_rise[i] = cs_rise[i];
    end
    cpol = p_cpol; cpha = p_cpha; div = DVW'(p_div); sel = SW'(p_sel);
    nend = CW'(p_nend); all1 = p_f1; all0 = p_f0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Inputs must have been latched; scramble them for the rest of the burst.
    cpol = 1'($urandom); cpha = 1'($urandom); div = DVW'($urandom);
    sel = SW'($urandom); nend = CW'($urandom); all1 = 1'($urandom); all0 = 1'($urandom);
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (p_extra && c == 30) begin
        start = 1'b1;
        sel   = '0;
      end else begin
        start = 1'b0;
      end
      if (!busy) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("%s_timeout", name), 32'(fin), 32'd1);
    chk($sformatf("%s_rx_count", name), rxa_q.size() - b_rx, nw);
    for (int k = 0; k < nw && (b_rx + k) < rxa_q.size(); k++) begin
      exp_d = p_loop ? (p_f1 ? 8'hFF : (p_f0 ? 8'h00 : tx_mem[k])) : sl_mem[k];
      chk($sformatf("%s_rx_addr%0d", name, k), rxa_q[b_rx + k], k);
      chk($sformatf("%s_rx_data%0d", name, k), rxd_q[b_rx + k], 32'(exp_d));
    end
    chk($sformatf("%s_done", name), done_cnt - b_done, 1);
    chk($sformatf("%s_edges", name), edges_tot - b_edges, 2 * DW * nw);
    chk($sformatf("%s_half_period", name), bad_space - b_bad, 0);
    chk($sformatf("%s_sclk_idle_end", name), 32'(sclk), 32'(p_cpol));
    chk($sformatf("%s_sclk_idle_cs", name), idle_bad - b_idle, 0);
    chk($sformatf("%s_mosi_forced", name), mviol - b_mv, 0);
    for (int i = 0; i < NCS; i++) begin
      chk($sformatf("%s_cs%0d_fall", name, i), cs_fall[i] - b_fall[i], (i == p_sel) ? 1 : 0);
      chk($sformatf("%s_cs%0d_rise", name, i), cs_rise[i] - b_rise[i], (i == p_sel) ? 1 : 0);
    end
    chk($sformatf("%s_busy_end", name), 32'(busy), 32'd0);
    n_burst++;
    $display("burst %0d %s mode=%0d div=%0d sel=%0d words=%0d f1=%0d f0=%0d loop=%0d",
             n_burst, name, {p_cpol, p_cpha}, p_div, p_sel, nw, p_f1, p_f0, p_loop);
  endtask

  task automatic reset_mid_burst();
    int b_rx, b_done;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) tx_mem[k] = DW'($urandom);
    m_cpol = 1'b0; m_cpha = 1'b0; m_div = 1; m_f1 = 1'b0; m_f0 = 1'b0;
    loopback = 1'b1;
    @(negedge clk);
    b_rx = rxa_q.size(); b_done = done_cnt;
    cpol = 1'b0; cpha = 1'b0; div = 8'd1; sel = 2'd0; nend = 4'd3;
    all1 = 1'b0; all0 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rxa_q.size() > b_rx) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_first_word", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs_n", 32'(cs_n), 32'(3'b111));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_tx_addr", 32'(tx_addr), 32'd0);
    chk("rst_rx_we", 32'(rx_we), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("rst_no_more_we", rxa_q.size() - b_rx, 1);
    chk("rst_no_done", done_cnt - b_done, 0);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    $display("burst %0d reset_mid_burst words_before_reset=%0d", n_burst + 1, rxa_q.size() - b_rx);
    n_burst++;
  endtask

  initial begin
    int r;
    for (int k = 0; k < NW; k++) begin
      tx_mem[k] = '0;
      sl_mem[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_sclk", 32'(sclk), 32'd0);
    chk("reset_mosi", 32'(mosi), 32'd0);
    chk("reset_cs_n", 32'(cs_n), 32'(3'b111));
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_addrs", 32'({tx_addr, rx_addr}), 32'd0);
    chk("reset_strobes", 32'({rx_we, busy, done}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    tx_mem[0] = 8'hA5;
    run_burst("mode0_a5", 1'b0, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int m = 1; m < 4; m++) begin
      tx_mem[0] = 8'h3C;
      sl_mem[0] = 8'hC3;
      run_burst($sformatf("mode%0d_slave", m), m[1], m[0], 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33; tx_mem[3] = 8'h44;
    run_burst("four_words", 1'b0, 1'b0, 1, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0);

    tx_mem[0] = 8'h00;
    run_burst("force_ones", 1'b0, 1'b0, 1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    tx_mem[0] = 8'hFF;
    run_burst("force_zeros", 1'b1, 1'b1, 1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

    tx_mem[0] = 8'h5A; tx_mem[1] = 8'h96;
    run_burst("sel1_restart", 1'b0, 1'b1, 2, 1, 1, 1'b0, 1'b0, 1'b1, 1'b1);

    run_burst("sel_out_of_range", 1'b1, 1'b0, 0, 3, 1, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < NW; k++) tx_mem[k] = DW'($urandom);
    run_burst("full_range", 1'b0, 1'b0, 0, 2, NW - 1, 1'b0, 1'b0, 1'b1, 1'b0);

    reset_mid_burst();
    tx_mem[0] = 8'hC7; tx_mem[1] = 8'h18;
    run_burst("after_reset", 1'b0, 1'b0, 1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < NW; k++) begin
        tx_mem[k] = DW'($urandom);
        sl_mem[k] = DW'($urandom);
      end
      r = $urandom_range(0, 5);
      run_burst($sformatf("rand%0d", t), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 5), r == 0, r == 1,
                1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_burst.md
SPI_MASTER_BURST -- requirements
Module: spi_master_burst

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per SPI word.
REQ-002 The block SHALL have parameter DIV_W, default 8, meaning width of the clock-divider port.
REQ-003 The block SHALL have parameter CNT_W, default 10, meaning width of the word index and count.
REQ-004 The block SHALL have parameter N_CS, default 2, meaning number of chip-select lines.
REQ-005 clk_i  input  1  system clock; sole clock.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 start_i  input  1  starts a burst when idle.
REQ-008 cpol_i, cpha_i  input  1 each  SPI mode.
REQ-009 div_i  input  DIV_W  SCLK half-period is div_i+1 clk_i cycles.
REQ-010 cs_sel_i  input  $clog2(N_CS) (min 1)  selects the chip-select line.
REQ-011 n_tx_end_i  input  CNT_W  index of the last word; burst length is n_tx_end_i+1.
REQ-012 all_1s_i, all_0s_i  input  1 each  force MOSI high / low; all_1s_i wins.
REQ-013 tx_data_i  input  DATA_W  word at tx_addr_o, valid 1 cycle after tx_addr_o changes.
REQ-014 miso_i  input  1  serial data in.
REQ-015 sclk_o, mosi_o  output  1 each  serial clock and data out.
REQ-016 cs_n_o  output  N_CS  chip selects, active-low.
REQ-017 tx_addr_o, rx_addr_o  output  CNT_W  current read / write word index.
REQ-018 rx_data_o  output  DATA_W  last received word.
REQ-019 rx_we_o  output  1  1-cycle write strobe for rx_data_o at rx_addr_o.
REQ-020 busy_o, done_o  output  1 each  burst active; 1-cycle completion pulse.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, SETUP, SHIFT, STORE, HOLD.
REQ-022 IDLE: when start_i=1, the block SHALL latch cpol, cpha, div, cs_sel, n_tx_end and force flags, set tx_addr_o=0, and go to LOAD. start_i SHALL be ignored in every other state.
REQ-023 LOAD (1 cycle): the block SHALL capture tx_data_i into the shift register, assert the selected cs_n_o low, and go to SETUP.
REQ-024 SETUP: the block SHALL wait one half-period, then go to SHIFT.
REQ-025 SHIFT: the block SHALL transfer DATA_W bits MSB first, with SCLK toggling every div+1 cycles and idling at the CPOL level.
REQ-026 CPHA=0: MOSI SHALL be valid before the first edge; MISO SHALL be sampled on leading edges; MOSI SHALL change on trailing edges.
REQ-027 CPHA=1: MOSI SHALL change on leading edges; MISO SHALL be sampled on trailing edges.
REQ-028 When forced, MOSI SHALL be the constant 1 (all_1s) or 0 (all_0s) regardless of tx_data_i.
REQ-029 After the DATA_W-th sample and the final trailing edge, the block SHALL go to STORE.
REQ-030 STORE (1 cycle): the block SHALL set rx_data_o, pulse rx_we_o, and set rx_addr_o to the word index.
REQ-031 From STORE, if index==n_tx_end, the block SHALL go to HOLD; otherwise it SHALL increment tx_addr_o and go to LOAD with CS still low (no CS gap between words).
REQ-032 HOLD: the block SHALL wait one half-period, deassert all cs_n_o, pulse done_o for 1 cycle, and return to IDLE.
REQ-033 busy_o SHALL be 1 in every state except IDLE.
REQ-034 The index counter SHALL NOT wrap. n_tx_end = 2^CNT_W-1 SHALL yield 2^CNT_W words.
REQ-035 An out-of-range cs_sel SHALL assert no CS line, while the transfer still runs.

Reset
REQ-036 On rst_ni=0 (any state, asynchronous): state=IDLE; sclk_o=0; mosi_o=0; cs_n_o all 1; rx_data_o=0; tx_addr_o=0; rx_addr_o=0; rx_we_o=0; busy_o=0; done_o=0.
REQ-037 A reset mid-burst SHALL abort with no rx_we_o or done_o pulse. After release, sclk_o SHALL settle to the latched CPOL only on the next start.

Structure
REQ-038 The state enum, the mode encoding, and default parameter constants SHALL live in the shared package spi_pkg.
REQ-039 Half-period timing SHALL be a sub-module spi_clk_div (counter, reload div, tick output).

Verification
REQ-040 Mode 0, div=1, n_tx_end=0, tx=0xA5, MISO loops back from MOSI -> rx_data_o=0xA5, one rx_we_o at addr 0, done_o once, 8 SCLK periods of 4 clk each.
REQ-041 Modes 1, 2 and 3, tx=0x3C, slave model returns 0xC3 -> rx_data_o=0xC3 in every mode, SCLK idle level equals CPOL.
REQ-042 n_tx_end=3, words 0x11, 0x22, 0x33, 0x44 with loopback -> rx_we_o at addr 0..3 with matching data, CS low continuously, single done_o.
REQ-043 all_1s=1 and all_0s=1, tx=0x00 -> MOSI constantly 1; with all_0s only and tx=0xFF -> MOSI constantly 0.
REQ-044 rst_ni low during word 2 of 4 -> all CS high and IDLE immediately, no further rx_we_o; a new start completes normally.
REQ-045 start_i pulsed while busy and cs_sel=1 -> ignored, only cs_n_o[1] toggles.
